// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared constants and FSM state type for the IDCT merge stage
package idct_pkg;

    localparam int DW_DEFAULT            = 8;
    localparam int LANES                 = 4;
    localparam int BLOCK_SAMPLES_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FULL   = 2'd2
    } merge_state_e;

endpackage

// File: rtl/idct_fifo2.sv
// rtl/idct_fifo2.sv - two-entry buffer of packed 4-sample groups
module idct_fifo2 #(
    parameter int GW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [GW-1:0] push_data,
    output logic          full,
    output logic          empty,
    output logic [GW-1:0] head_data
);

    logic [GW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // Occupancy is unchanged by a simultaneous push and pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointers and occupancy; reset discards any buffered groups.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Group storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/idct_merge.sv
// rtl/idct_merge.sv - merges odd/even lane groups back into natural-order samples
module idct_merge
    import idct_pkg::*;
#(
    parameter int DW            = DW_DEFAULT,
    parameter int BLOCK_SAMPLES = BLOCK_SAMPLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_o1,
    input  logic [DW-1:0] in_o2,
    input  logic [DW-1:0] in_e1,
    input  logic [DW-1:0] in_e2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int GW = LANES * DW;
    localparam int CW = (BLOCK_SAMPLES > 1) ? $clog2(BLOCK_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_SAMPLES - 1);

    merge_state_e  state_q;
    merge_state_e  state_d;
    logic [1:0]    lane_q;
    logic [1:0]    lane_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [GW-1:0] head_group;
    logic [GW-1:0] push_group;
    logic          push;
    logic          pop;
    logic          xfer;

    // Lane slot k holds natural-order sample k: o1, e1, o2, e2.
    assign push_group = {in_e2, in_o2, in_e1, in_o1};

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (lane_q == 2'd3);

    assign out_data = out_valid ? head_group[lane_q*DW +: DW] : '0;
    assign out_last = out_valid && (cnt_q == CNT_LAST);
    assign busy     = (state_q != ST_IDLE);

    idct_fifo2 #(
        .GW (GW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_group),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_group)
    );

    // State tracks buffer occupancy after each push/pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (push && !pop) begin
                    state_d = ST_FULL;
                end else if (pop && !push) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_STREAM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane index and block framing counter advance on every output transfer.
    always_comb begin
        lane_d = lane_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            lane_d = lane_q + 2'd1;
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Control registers; reset restarts framing at sample 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_idct_merge.sv
// tb/tb_idct_merge.sv - scoreboard bench for idct_merge
module tb_idct_merge;

    localparam int DW = 8;
    localparam int BS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_o1, in_o2, in_e1, in_e2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int model_cnt = 0;
    int last_seen = 0;
    int c0;

    logic [DW:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_out;

    idct_merge #(
        .DW            (DW),
        .BLOCK_SAMPLES (BS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_o1     (in_o1),
        .in_o2     (in_o2),
        .in_e1     (in_e1),
        .in_e2     (in_e2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every output transfer against the scoreboard and checks holds under stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_data", {23'd0, out_last, out_data}, {23'd0, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("sample", {23'd0, out_last, out_data}, {23'd0, e});
                    if (out_last) last_seen++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
        end
    end

    task automatic exp_push(input logic [DW-1:0] d);
        exp_q.push_back({(model_cnt == BS - 1), d});
        model_cnt = (model_cnt + 1) % BS;
    endtask

    task automatic push_group(input logic [DW-1:0] o1, input logic [DW-1:0] e1,
                              input logic [DW-1:0] o2, input logic [DW-1:0] e2);
        bit done = 0;
        in_o1 = o1; in_e1 = e1; in_o2 = o2; in_e2 = e2;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
                accept_cyc = cyc;
                exp_push(o1); exp_push(e1); exp_push(o2); exp_push(e2);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_o1 = '0; in_o2 = '0; in_e1 = '0; in_e2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single group, latency and order
        out_ready = 1'b1;
        push_group(8'h11, 8'h22, 8'h33, 8'h44);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'h11);
        chk("lat_busy", busy, 1);
        drain();
        chk("single_done_valid", out_valid, 0);
        chk("single_done_busy", busy, 0);

        // Full buffer: third group refused until the first pop
        out_ready = 1'b0;
        push_group(8'h01, 8'h02, 8'h03, 8'h04);
        push_group(8'h05, 8'h06, 8'h07, 8'h08);
        in_o1 = 8'h09; in_e1 = 8'h0A; in_o2 = 8'h0B; in_e2 = 8'h0C; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c0 = cyc;
        push_group(8'h09, 8'h0A, 8'h0B, 8'h0C);
        chk("full_accept_delay", accept_cyc - c0, 5);
        drain();
        chk("full_done_valid", out_valid, 0);

        // Backpressure: out_ready toggles every cycle
        fork
            begin
                push_group(8'hA0, 8'hA1, 8'hA2, 8'hA3);
                push_group(8'hB0, 8'hB1, 8'hB2, 8'hB3);
            end
            begin
                repeat (24) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("bp_done_valid", out_valid, 0);

        // Reset after 6 of 8 buffered samples, with a push presented during reset
        out_ready = 1'b0;
        push_group(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        push_group(8'hC4, 8'hC5, 8'hC6, 8'hC7);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        in_o1 = 8'hEE; in_e1 = 8'hEE; in_o2 = 8'hEE; in_e2 = 8'hEE; in_valid = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_last", out_last, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_discard", out_valid, 0);

        // Framing: 64 samples 0..63 then one more group
        last_seen = 0;
        for (int g = 0; g < 16; g++) begin
            push_group(8'(4*g), 8'(4*g+1), 8'(4*g+2), 8'(4*g+3));
        end
        push_group(8'h80, 8'h81, 8'h82, 8'h83);
        drain();
        chk("frame_last_count", last_seen, 1);
        chk("frame_done_valid", out_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
